// File: rtl/fifo_ram_pkg.sv
// Shared constants and types for the 16K x 8 single-clock FIFO.
// The top level and the RAM take their default widths from here.
package fifo_ram_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int ADDR_WIDTH = 14;
  localparam int DEPTH      = 1 << ADDR_WIDTH;

  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef logic [ADDR_WIDTH:0]   count_t;
  typedef logic [DATA_WIDTH-1:0] data_t;

endpackage

// File: rtl/fifo_ram_mem.sv
// Simple dual-port RAM: one write port and one registered read port on a single clock.
// It has no reset, so synthesis can map it to block RAM.
module fifo_ram_mem #(
  parameter int DATA_WIDTH = fifo_ram_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = fifo_ram_pkg::ADDR_WIDTH
) (
  input  logic                  clock,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [1 << ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] rd_data_q;

  // The FIFO never reads and writes the same address in one cycle.
  // So the read-during-write behaviour of the RAM does not matter.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data_q <= mem[rd_addr];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/fifo_ram_16k.sv
// Single-clock FIFO, 16384 x 8, backed by fifo_ram_mem.
// This level holds the pointers, the occupancy count, the registered flags and the accept logic.
module fifo_ram_16k #(
  parameter int DATA_WIDTH = fifo_ram_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = fifo_ram_pkg::ADDR_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  read,
  input  logic                  write,
  input  logic                  enable,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty
);

  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;
  logic                  valid_q, valid_d;
  logic                  push_ok, pop_ok;
  logic [DATA_WIDTH-1:0] rd_data;

  always_comb begin
    push_ok   = enable & write & ~full_q;
    pop_ok    = enable & read & ~empty_q;
    wr_addr_d = wr_addr_q;
    rd_addr_d = rd_addr_q;
    count_d   = count_q;
    if (push_ok) begin
      wr_addr_d = wr_addr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_addr_d = rd_addr_q + 1'b1;
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    full_d  = (count_d == DEPTH_CNT);
    empty_d = (count_d == '0);
    // The RAM output register has no reset, so data_out is forced to zero
    // until the first pop after reset.
    valid_d = valid_q | pop_ok;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_addr_q <= '0;
      rd_addr_q <= '0;
      count_q   <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      valid_q   <= 1'b0;
    end else begin
      wr_addr_q <= wr_addr_d;
      rd_addr_q <= rd_addr_d;
      count_q   <= count_d;
      full_q    <= full_d;
      empty_q   <= empty_d;
      valid_q   <= valid_d;
    end
  end

  fifo_ram_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_mem (
    .clock   (clock),
    .wr_en   (push_ok),
    .wr_addr (wr_addr_q),
    .wr_data (data_in),
    .rd_en   (pop_ok),
    .rd_addr (rd_addr_q),
    .rd_data (rd_data)
  );

  assign data_out = valid_q ? rd_data : '0;
  assign full     = full_q;
  assign empty    = empty_q;

endmodule

// File: tb/tb_fifo_ram_16k.sv
// Directed bench for fifo_ram_16k: runs one task per scenario, checks values inline,
// and prints one line per transaction.
module tb_fifo_ram_16k;

  logic       clock;
  logic       reset;
  logic [7:0] data_in;
  logic       read;
  logic       write;
  logic       enable;
  logic [7:0] data_out;
  logic       full;
  logic       empty;

  int errors = 0;
  int checks = 0;

  fifo_ram_16k dut (
    .clock    (clock),
    .reset    (reset),
    .data_in  (data_in),
    .read     (read),
    .write    (write),
    .enable   (enable),
    .data_out (data_out),
    .full     (full),
    .empty    (empty)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one edge and settle; the bench samples and drives 1 ns after the rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; enable = 1'b0; read = 1'b0; write = 1'b0; data_in = 8'h00;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    checks++;
    if (data_out !== 8'h00 || empty !== 1'b1 || full !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: data_out=%h empty=%b full=%b, required 00/1/0", data_out, empty, full);
    end
    enable = 1'b1; read = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (data_out !== 8'h00 || empty !== 1'b1 || full !== 1'b0) begin
        errors++;
        $display("FAIL reset_read_empty[%0d]: data_out=%h empty=%b full=%b, required 00/1/0", i, data_out, empty, full);
      end
    end
    read = 1'b0;
    $display("reset: done");
  endtask

  task automatic test_enable();
    enable = 1'b0; write = 1'b1; data_in = 8'h55;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (empty !== 1'b1) begin
        errors++;
        $display("FAIL enable_gate_write[%0d]: empty=%b, required 1", i, empty);
      end
    end
    write = 1'b0; enable = 1'b1; read = 1'b1;
    tick();
    checks++;
    if (data_out !== 8'h00 || empty !== 1'b1) begin
      errors++;
      $display("FAIL enable_gate_read: data_out=%h empty=%b, required 00/1", data_out, empty);
    end
    read = 1'b0;
    $display("enable: gated writes ignored");
  endtask

  task automatic test_order();
    enable = 1'b1; write = 1'b1;
    for (int i = 0; i < 50; i++) begin
      data_in = 8'(i);
      tick();
      checks++;
      if (empty !== 1'b0) begin
        errors++;
        $display("FAIL order_push_empty[%0d]: empty=%b, required 0", i, empty);
      end
    end
    write = 1'b0; read = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      checks++;
      if (data_out !== 8'(i)) begin
        errors++;
        $display("FAIL order_pop[%0d]: data_out=%h, required %h", i, data_out, 8'(i));
      end
    end
    read = 1'b0;
    checks++;
    if (empty !== 1'b1 || full !== 1'b0) begin
      errors++;
      $display("FAIL order_final_empty: empty=%b full=%b, required 1/0", empty, full);
    end
    $display("order: 50 words pushed and popped");
  endtask

  task automatic test_fill_full();
    enable = 1'b1; write = 1'b1;
    for (int i = 0; i < 16384; i++) begin
      data_in = 8'(i % 256);
      tick();
      if (i == 16382) begin
        checks++;
        if (full !== 1'b0) begin
          errors++;
          $display("FAIL full_early: full=%b after 16383 pushes, required 0", full);
        end
      end
    end
    checks++;
    if (full !== 1'b1 || empty !== 1'b0) begin
      errors++;
      $display("FAIL full_set: full=%b empty=%b, required 1/0", full, empty);
    end
    data_in = 8'hAA;
    tick();
    write = 1'b0;
    checks++;
    if (full !== 1'b1) begin
      errors++;
      $display("FAIL full_drop: full=%b after dropped push, required 1", full);
    end
    read = 1'b1;
    for (int i = 0; i < 16384; i++) begin
      tick();
      checks++;
      if (data_out !== 8'(i % 256)) begin
        errors++;
        $display("FAIL full_pop[%0d]: data_out=%h, required %h", i, data_out, 8'(i % 256));
      end
      if (i == 0) begin
        checks++;
        if (full !== 1'b0) begin
          errors++;
          $display("FAIL full_clear: full=%b after first pop, required 0", full);
        end
      end
    end
    read = 1'b0;
    checks++;
    if (empty !== 1'b1 || full !== 1'b0) begin
      errors++;
      $display("FAIL full_drained: empty=%b full=%b, required 1/0", empty, full);
    end
    $display("fill_full: 16384 words pushed and popped, 0xAA dropped");
  endtask

  task automatic test_simultaneous();
    logic [7:0] exp;
    enable = 1'b1; write = 1'b1;
    for (int i = 0; i < 4; i++) begin
      data_in = 8'h10 + 8'(i);
      tick();
    end
    read = 1'b1;
    for (int i = 0; i < 8; i++) begin
      data_in = 8'h20 + 8'(i);
      tick();
      exp = (i < 4) ? 8'h10 + 8'(i) : 8'h20 + 8'(i - 4);
      checks++;
      if (data_out !== exp || full !== 1'b0 || empty !== 1'b0) begin
        errors++;
        $display("FAIL simul[%0d]: data_out=%h full=%b empty=%b, required %h/0/0", i, data_out, full, empty, exp);
      end
    end
    write = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      exp = 8'h24 + 8'(i);
      checks++;
      if (data_out !== exp) begin
        errors++;
        $display("FAIL simul_drain[%0d]: data_out=%h, required %h", i, data_out, exp);
      end
    end
    read = 1'b0;
    checks++;
    if (empty !== 1'b1) begin
      errors++;
      $display("FAIL simul_final_empty: empty=%b, required 1", empty);
    end
    $display("simultaneous: count held at 4 over 8 cycles");
  endtask

  task automatic test_boundary_reset();
    enable = 1'b1; read = 1'b1; write = 1'b1; data_in = 8'h7E;
    tick();
    read = 1'b0; write = 1'b0;
    checks++;
    if (data_out !== 8'h27 || empty !== 1'b0) begin
      errors++;
      $display("FAIL empty_both: data_out=%h empty=%b, required 27/0", data_out, empty);
    end
    read = 1'b1;
    tick();
    read = 1'b0;
    checks++;
    if (data_out !== 8'h7E || empty !== 1'b1) begin
      errors++;
      $display("FAIL empty_both_pop: data_out=%h empty=%b, required 7e/1", data_out, empty);
    end
    write = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      data_in = 8'(i);
      tick();
    end
    write = 1'b0;
    reset = 1'b0;
    #1;
    checks++;
    if (empty !== 1'b1 || data_out !== 8'h00 || full !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: empty=%b data_out=%h full=%b, required 1/00/0", empty, data_out, full);
    end
    tick();
    reset = 1'b1;
    read = 1'b1;
    tick();
    read = 1'b0;
    checks++;
    if (data_out !== 8'h00 || empty !== 1'b1) begin
      errors++;
      $display("FAIL pop_after_reset: data_out=%h empty=%b, required 00/1", data_out, empty);
    end
    write = 1'b1; data_in = 8'h99;
    tick();
    write = 1'b0; read = 1'b1;
    tick();
    read = 1'b0;
    checks++;
    if (data_out !== 8'h99 || empty !== 1'b1) begin
      errors++;
      $display("FAIL reuse_after_reset: data_out=%h empty=%b, required 99/1", data_out, empty);
    end
    $display("boundary_reset: empty push-only and mid-stream reset");
  endtask

  initial begin
    test_reset();
    test_enable();
    test_order();
    test_fill_full();
    test_simultaneous();
    test_boundary_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
